hazard_wall_ctrl: RTL and testbench

- Parametrised advancing-hazard controller for the side-scroller: a lava or hazard wall sweeps across the playfield after the player's first move.
- Uses a sub-pixel position accumulator, a saturating speed ramp driven by score boosts, and a configurable sweep direction.
- Provides a restart without reset.
- Sits between the game FSM (freeze/restart), input block (any_input_level), scoring (speed_boost_pulse) and renderer/collision consumers.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_wall_ctrl_if.sv | 25 ++
 rtl/hazard_speed_ramp.sv | 31 +++
 rtl/hazard_wall_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_wall_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-wall definitions: FSM encoding, fixed-point helpers and
// game-wide playfield/tick constants also used by the renderer.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } wall_state_e;

  localparam int FRAC_W_DEF    = 4;
  localparam int ONE_PX        = 1 << FRAC_W_DEF;
  localparam int GAME_SCREEN_W = 640;
  localparam int GAME_TICK_HZ  = 60;

endpackage

// File: rtl/hazard_wall_ctrl_if.sv
// Game-side bus of the hazard wall: tick/control strobes in, wall state out.
interface hazard_wall_ctrl_if #(
  parameter int X_W = 10
);
  logic           game_tick;
  logic           any_input_level;
  logic           speed_boost_pulse;
  logic           freeze;
  logic           restart;
  logic [X_W-1:0] player_x;
  logic [X_W-1:0] lava_wall_x;
  logic [7:0]     lava_speed;
  logic           lava_active;
  logic           hit_lava_wall;

  modport master (
    output game_tick, any_input_level, speed_boost_pulse, freeze, restart, player_x,
    input  lava_wall_x, lava_speed, lava_active, hit_lava_wall
  );

  modport slave (
    input  game_tick, any_input_level, speed_boost_pulse, freeze, restart, player_x,
    output lava_wall_x, lava_speed, lava_active, hit_lava_wall
  );
endinterface

// File: rtl/hazard_speed_ramp.sv
// Saturating fixed-point speed accumulator; reusable by any ramping hazard.
module hazard_speed_ramp #(
  parameter int W    = 8,
  parameter int INIT = 16,
  parameter int STEP = 8,
  parameter int MAX  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] speed
);

  logic [W:0]   sum;
  logic [W-1:0] nxt;

  // one extra bit so the pre-clamp sum can never wrap
  always_comb begin
    sum = {1'b0, speed} + (W+1)'(STEP);
    nxt = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            speed <= W'(INIT);
    else if (clr)        speed <= W'(INIT);
    else if (en && inc)  speed <= nxt;
  end

endmodule

// File: rtl/hazard_wall_ctrl.sv
// Advancing hazard wall: arm on first input, delayed start, sub-pixel sweep
// with boostable speed, and a registered player overlap flag.
module hazard_wall_ctrl
  import hazard_pkg::*;
#(
  parameter int X_W         = 10,
  parameter int SCREEN_W    = GAME_SCREEN_W,
  parameter int WALL_W      = 10,
  parameter int DELAY_TICKS = 120,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int SPEED_INIT  = 16,
  parameter int SPEED_STEP  = 8,
  parameter int SPEED_MAX   = 64,
  parameter bit DIR_RIGHT   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  hazard_wall_ctrl_if.slave bus
);

  localparam int PW = X_W + FRAC_W;
  localparam int DW = $clog2(DELAY_TICKS) + 1;
  localparam logic [PW-1:0] POS_MAX = PW'(SCREEN_W << FRAC_W);

  wall_state_e    state;
  logic [PW-1:0]  pos;
  logic [DW-1:0]  delay_cnt;
  logic [X_W-1:0] wall_x;
  logic           active_q;
  logic           hit_q;
  logic [7:0]     speed;

  logic           upd;
  logic           clr;
  logic [PW:0]    pos_sum;
  logic           pos_sat;
  logic [PW-1:0]  pos_nxt;
  logic [X_W:0]   wx_e;
  logic [X_W:0]   px_e;
  logic [X_W:0]   edge_x;
  logic           overlap;

  assign clr = bus.game_tick && bus.restart;
  assign upd = bus.game_tick && !bus.restart && !bus.freeze;

  hazard_speed_ramp #(
    .W    (8),
    .INIT (SPEED_INIT),
    .STEP (SPEED_STEP),
    .MAX  (SPEED_MAX)
  ) u_ramp (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (upd),
    .inc   (bus.speed_boost_pulse),
    .speed (speed)
  );

  // move uses the speed registered before any same-tick boost
  always_comb begin
    pos_sum = {1'b0, pos} + (PW+1)'(speed);
    pos_sat = pos_sum >= {1'b0, POS_MAX};
    pos_nxt = pos_sat ? POS_MAX : pos_sum[PW-1:0];
  end

  always_comb begin
    wx_e    = {1'b0, wall_x};
    px_e    = {1'b0, bus.player_x};
    edge_x  = '0;
    overlap = 1'b0;
    if (DIR_RIGHT) begin
      overlap = (wx_e + (X_W+1)'(WALL_W)) >= px_e;
    end else begin
      edge_x  = (X_W+1)'(SCREEN_W) - wx_e;
      overlap = edge_x <= (px_e + (X_W+1)'(WALL_W));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pos       <= '0;
      delay_cnt <= '0;
      wall_x    <= '0;
      active_q  <= 1'b0;
      hit_q     <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      pos       <= '0;
      delay_cnt <= '0;
      wall_x    <= '0;
      active_q  <= 1'b0;
      hit_q     <= 1'b0;
    end else if (upd) begin
      hit_q <= active_q && overlap;
      case (state)
        IDLE: if (bus.any_input_level) begin
          state     <= ARMED;
          delay_cnt <= '0;
        end
        ARMED: begin
          delay_cnt <= delay_cnt + 1'b1;
          if (delay_cnt == DW'(DELAY_TICKS - 1)) begin
            state    <= ACTIVE;
            active_q <= 1'b1;
          end
        end
        ACTIVE: begin
          pos    <= pos_nxt;
          wall_x <= pos_nxt[PW-1:FRAC_W];
          if (pos_sat) state <= DONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.lava_wall_x   = wall_x;
  assign bus.lava_speed    = speed;
  assign bus.lava_active   = active_q;
  assign bus.hit_lava_wall = hit_q;

endmodule

// File: tb/tb_hazard_wall_ctrl.sv
// Directed bench: right-sweeping and left-sweeping walls driven in lockstep.
module tb_hazard_wall_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_wall_ctrl_if #(.X_W(10)) ifa ();
  hazard_wall_ctrl_if #(.X_W(10)) ifb ();

  hazard_wall_ctrl #(.DIR_RIGHT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  hazard_wall_ctrl #(.DIR_RIGHT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic tk, input logic inp, input logic bst,
                       input logic frz, input logic rs);
    ifa.game_tick = tk;  ifa.any_input_level = inp; ifa.speed_boost_pulse = bst;
    ifa.freeze    = frz; ifa.restart         = rs;
    ifb.game_tick = tk;  ifb.any_input_level = inp; ifb.speed_boost_pulse = bst;
    ifb.freeze    = frz; ifb.restart         = rs;
  endtask

  task automatic tick(input logic inp, input logic bst, input logic frz, input logic rs);
    @(negedge clk);
    drive(1'b1, inp, bst, frz, rs);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // strobes held without game_tick must be ignored
  task automatic no_tick_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},      ifa.lava_wall_x,   0);
    chk({tag, "_speed"},  ifa.lava_speed,    16);
    chk({tag, "_active"}, ifa.lava_active,   0);
    chk({tag, "_hit"},    ifa.hit_lava_wall, 0);
  endtask

  // arm, run unboosted to wall 40 (A probe) and wall 100 (B probe), then restart
  task automatic collision_run(input logic [9:0] pa, input logic [9:0] pb,
                               input logic expa, input logic expb, input bit first);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(119);
    if (first) chk("arm_active_119", ifa.lava_active, 0);
    ticks(1);
    if (first) begin
      chk("arm_active_120", ifa.lava_active, 1);
      chk("arm_x_120", ifa.lava_wall_x, 0);
      ticks(1); chk("arm_x_121", ifa.lava_wall_x, 1);
      ticks(1); chk("arm_x_122", ifa.lava_wall_x, 2);
      ticks(1); chk("arm_x_123", ifa.lava_wall_x, 3);
      ticks(37);
    end else begin
      ticks(40);
    end
    chk("col_a_wall40", ifa.lava_wall_x, 40);
    ifa.player_x = pa;
    ticks(1);
    chk("col_a_hit", ifa.hit_lava_wall, 32'(expa));
    ticks(1);
    chk("col_a_hold", ifa.hit_lava_wall, 1);
    ifa.player_x = 10'd1023;
    ticks(58);
    chk("col_b_wall100", ifb.lava_wall_x, 100);
    ifb.player_x = pb;
    ticks(1);
    chk("col_b_hit", ifb.hit_lava_wall, 32'(expb));
    ifb.player_x = 10'd0;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ifa.player_x = 10'd1023;
    ifb.player_x = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b1;

    ticks(50);
    chk_reset_vals("idle50");
    no_tick_clks(3);
    chk_reset_vals("notick_idle");

    // arm, then freeze 10 ticks mid-ARMED with boosts and input held
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(50);
    repeat (10) tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("frz_speed",  ifa.lava_speed,  16);
    chk("frz_active", ifa.lava_active, 0);
    chk("frz_x",      ifa.lava_wall_x, 0);
    ticks(69);
    chk("frz_active_119", ifa.lava_active, 0);
    ticks(1);
    chk("frz_active_120", ifa.lava_active, 1);
    chk("frz_x_120", ifa.lava_wall_x, 0);
    ticks(1);
    chk("mv_x1", ifa.lava_wall_x, 1);
    no_tick_clks(3);
    chk("notick_x",     ifa.lava_wall_x, 1);
    chk("notick_speed", ifa.lava_speed,  16);
    chk("notick_act",   ifa.lava_active, 1);
    ticks(2);
    chk("mv_x3", ifa.lava_wall_x, 3);

    // one boost: same-tick move at 1.0, then 1.5 px/tick
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("boost_x4",    ifa.lava_wall_x, 4);
    chk("boost_speed", ifa.lava_speed,  24);
    ticks(1); chk("frac_x5",  ifa.lava_wall_x, 5);
    ticks(1); chk("frac_x7",  ifa.lava_wall_x, 7);
    ticks(1); chk("frac_x8",  ifa.lava_wall_x, 8);
    ticks(1); chk("frac_x10", ifa.lava_wall_x, 10);

    repeat (7) tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("cap_speed", ifa.lava_speed,  64);
    chk("cap_x30",   ifa.lava_wall_x, 30);

    ticks(152);
    chk("sat_x638",   ifa.lava_wall_x, 638);
    chk("sat_active", ifa.lava_active, 1);
    ticks(1);
    chk("sat_x640", ifa.lava_wall_x, 640);
    ticks(5);
    chk("done_x640",   ifa.lava_wall_x,   640);
    chk("done_speed",  ifa.lava_speed,    64);
    chk("done_active", ifa.lava_active,   1);
    chk("done_hit_a",  ifa.hit_lava_wall, 0);
    chk("done_x_b",    ifb.lava_wall_x,   640);
    chk("done_hit_b",  ifb.hit_lava_wall, 1);

    // freeze must hold the hit flag too
    ifb.player_x = 10'd200;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    chk("frz_hold_hit_b", ifb.hit_lava_wall, 1);
    ifb.player_x = 10'd0;

    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk_reset_vals("restart");
    chk("restart_hit_b", ifb.hit_lava_wall, 0);

    collision_run(10'd50, 10'd530, 1'b1, 1'b1, 1'b1);
    collision_run(10'd51, 10'd529, 1'b0, 1'b0, 1'b0);

    // reset mid-run returns everything at once
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(130);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
